// File: rtl/lock_pkg.sv
// Shared types and default configuration for the sequential combination lock.
// Optional lockout support is enabled with the LOCK_LOCKOUT_EN macro.
package lock_pkg;

    // Lock controller states; LOCKOUT is only reachable with LOCK_LOCKOUT_EN
    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } lock_state_e;

    // Decoded meaning of the two push buttons on one clock edge
    typedef enum logic [1:0] {
        KEY_IDLE  = 2'd0,
        KEY_D0    = 2'd1,
        KEY_D1    = 2'd2,
        KEY_ABORT = 2'd3
    } key_e;

    localparam int DEF_CODE_LEN = 6;
    // MSB is the first digit entered: sequence 0,1,1,0,0,1
    localparam logic [DEF_CODE_LEN-1:0] DEF_CODE = 6'b011001;

`ifdef LOCK_LOCKOUT_EN
    localparam int DEF_MAX_FAIL       = 3;
    localparam int DEF_LOCKOUT_CYCLES = 16;
`endif

    // True when the key carries a digit (either 0 or 1)
    function automatic logic key_is_digit(input key_e k);
        return (k == KEY_D0) || (k == KEY_D1);
    endfunction

endpackage

// File: rtl/lock_key_decode.sv
// Combinational decode of the two synchronised push buttons into a key event.
module lock_key_decode
    import lock_pkg::*;
(
    input  logic inp0_i,
    input  logic inp1_i,
    output key_e key_o
);

    // Both pressed aborts the attempt, neither pressed is an idle cycle
    always_comb begin
        unique case ({inp1_i, inp0_i})
            2'b01:   key_o = KEY_D0;
            2'b10:   key_o = KEY_D1;
            2'b11:   key_o = KEY_ABORT;
            default: key_o = KEY_IDLE;
        endcase
    end

endmodule

// File: rtl/lock_fsm.sv
// Sequential combination lock: collects CODE_LEN digits per attempt and
// unlocks when the attempt equals CODE. Define LOCK_LOCKOUT_EN to add a
// lockout period after MAX_FAIL consecutive wrong attempts.
module lock_fsm
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN       = DEF_CODE_LEN,
    parameter logic [CODE_LEN-1:0] CODE           = CODE_LEN'(DEF_CODE)
`ifdef LOCK_LOCKOUT_EN
    ,
    parameter int                  MAX_FAIL       = DEF_MAX_FAIL,
    parameter int                  LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic inp0,
    input  logic inp1,
    output logic out
);

    localparam int CNT_W = $clog2(CODE_LEN + 1);

    key_e                 key;
    logic                 digit_bit;
    logic [CODE_LEN-1:0]  attempt;

    lock_state_e          state_q, state_d;
    // Holds the digits entered so far; the newest digit completes the value
    logic [CODE_LEN-2:0]  hist_q, hist_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_q, out_d;

`ifdef LOCK_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LO_W   = $clog2(LOCKOUT_CYCLES + 1);
    logic [FAIL_W-1:0]    fail_q, fail_d;
    logic [LO_W-1:0]      lo_q, lo_d;
`endif

    lock_key_decode u_key_decode (
        .inp0_i (inp0),
        .inp1_i (inp1),
        .key_o  (key)
    );

    assign digit_bit = (key == KEY_D1);
    assign attempt   = {hist_q, digit_bit};

    // Next-state logic: digit framing, code compare and relock rules
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        cnt_d   = cnt_q;
`ifdef LOCK_LOCKOUT_EN
        fail_d  = fail_q;
        lo_d    = lo_q;
`endif
        unique case (state_q)
            LOCKED: begin
                if (key == KEY_ABORT) begin
                    cnt_d  = '0;
                    hist_d = '0;
                end else if (key_is_digit(key)) begin
                    if (cnt_q == CNT_W'(CODE_LEN - 1)) begin
                        // Last digit of the attempt: compare and restart framing
                        cnt_d  = '0;
                        hist_d = '0;
                        if (attempt == CODE) begin
                            state_d = UNLOCKED;
`ifdef LOCK_LOCKOUT_EN
                            fail_d  = '0;
`endif
                        end else begin
`ifdef LOCK_LOCKOUT_EN
                            if (fail_q >= FAIL_W'(MAX_FAIL - 1)) begin
                                state_d = LOCKOUT;
                                fail_d  = FAIL_W'(MAX_FAIL);
                                lo_d    = LO_W'(LOCKOUT_CYCLES);
                            end else begin
                                fail_d  = fail_q + FAIL_W'(1);
                            end
`endif
                        end
                    end else begin
                        hist_d = attempt[CODE_LEN-2:0];
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
            UNLOCKED: begin
                if (key == KEY_ABORT) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                    hist_d  = '0;
                end else if (key_is_digit(key)) begin
                    // The relocking digit is the first digit of a new attempt
                    state_d = LOCKED;
                    hist_d  = (CODE_LEN-1)'(digit_bit);
                    cnt_d   = CNT_W'(1);
                end
            end
`ifdef LOCK_LOCKOUT_EN
            LOCKOUT: begin
                // Inputs ignored; leave once the down-counter reaches zero
                if (lo_q <= LO_W'(1)) begin
                    state_d = LOCKED;
                    lo_d    = '0;
                    fail_d  = '0;
                    cnt_d   = '0;
                    hist_d  = '0;
                end else begin
                    lo_d = lo_q - LO_W'(1);
                end
            end
`endif
            default: begin
                state_d = LOCKED;
                cnt_d   = '0;
                hist_d  = '0;
            end
        endcase
        out_d = (state_d == UNLOCKED);
    end

    // State and registered unlock output with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= LOCKED;
            hist_q  <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
`ifdef LOCK_LOCKOUT_EN
            fail_q  <= '0;
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
`ifdef LOCK_LOCKOUT_EN
            fail_q  <= fail_d;
            lo_q    <= lo_d;
`endif
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_lock_fsm.sv
// Self-checking bench for lock_fsm: vector table, hand sequences for reset
// and lockout corners, and randomized keys against a behavioural model.
module tb_lock_fsm;

    localparam int             CODE_LEN       = 6;
    localparam logic [5:0]     CODE           = 6'b011001;
    localparam int             MAX_FAIL       = 3;
    localparam int             LOCKOUT_CYCLES = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic inp0  = 1'b0;
    logic inp1  = 1'b0;
    logic dut_out;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lock_fsm #(
        .CODE_LEN       (CODE_LEN),
        .CODE           (CODE)
`ifdef LOCK_LOCKOUT_EN
        ,
        .MAX_FAIL       (MAX_FAIL),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
`endif
    ) dut (
        .clock (clock),
        .reset (reset),
        .inp0  (inp0),
        .inp1  (inp1),
        .out   (dut_out)
    );

    // ---------------- behavioural reference model ----------------
    bit m_attempt[$];
    bit m_unlocked;
    int m_fails;
    int m_lock_left;

    function automatic void model_reset();
        m_attempt.delete();
        m_unlocked  = 1'b0;
        m_fails     = 0;
        m_lock_left = 0;
    endfunction

    function automatic void model_step(input bit i0, input bit i1);
        int v;
        if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) begin
                m_fails = 0;
                m_attempt.delete();
            end
            return;
        end
        if (i0 && i1) begin
            m_attempt.delete();
            m_unlocked = 1'b0;
        end else if (i0 != i1) begin
            if (m_unlocked) begin
                m_unlocked = 1'b0;
                m_attempt.delete();
            end
            m_attempt.push_back(i1);
            if (m_attempt.size() == CODE_LEN) begin
                v = 0;
                foreach (m_attempt[k]) v = v * 2 + int'(m_attempt[k]);
                if (v == int'(CODE)) begin
                    m_unlocked = 1'b1;
                    m_fails    = 0;
                end else begin
                    m_fails++;
`ifdef LOCK_LOCKOUT_EN
                    if (m_fails >= MAX_FAIL) m_lock_left = LOCKOUT_CYCLES;
`endif
                end
                m_attempt.delete();
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: out=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    // One edge with given keys; DUT compared against the model
    task automatic step(input bit i0, input bit i1, input string name);
        inp0 = i0;
        inp1 = i1;
        @(posedge clock);
        model_step(i0, i1);
        #1;
        check(name, dut_out, m_unlocked);
    endtask

    task automatic key_char(input byte c, output bit i0, output bit i1);
        i0 = (c == "0") || (c == "a");
        i1 = (c == "1") || (c == "a");
    endtask

    task automatic enter_code(input string name);
        for (int k = CODE_LEN - 1; k >= 0; k--) begin
            logic [5:0] c;
            c = CODE;
            step(!c[k], c[k], name);
        end
    endtask

    typedef struct {
        bit    i0;
        bit    i1;
        bit    exp;
        string name;
    } vec_t;

    vec_t tbl[$];

    // keys: '0' digit 0, '1' digit 1, '.' idle, 'a' abort; exp: '0'/'1' out
    task automatic add_seq(input string name, input string keys, input string exps);
        for (int k = 0; k < keys.len(); k++) begin
            vec_t v;
            key_char(keys[k], v.i0, v.i1);
            v.exp  = (exps[k] == "1");
            v.name = name;
            tbl.push_back(v);
        end
    endtask

    initial begin
        bit r0, r1;

        add_seq("code_gaps", "0.11.00.1..", "00000000111");
        add_seq("relock",    "00110.1",     "0000000");
        add_seq("abort",     "011a011001a", "00000000010");

        // Reset held for 5 cycles with random keys: out must stay low
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            inp0 = 1'($urandom);
            inp1 = 1'($urandom);
            @(posedge clock);
            #1;
            check("reset_hold", dut_out, 1'b0);
        end
        reset = 1'b1;
        inp0  = 1'b0;
        inp1  = 1'b0;

        // Table-driven vectors; model kept in step for later phases
        for (int k = 0; k < tbl.size(); k++) begin
            inp0 = tbl[k].i0;
            inp1 = tbl[k].i1;
            @(posedge clock);
            model_step(tbl[k].i0, tbl[k].i1);
            #1;
            $display("vec %0d %s keys=%b%b out=%b exp=%b", k, tbl[k].name,
                     tbl[k].i1, tbl[k].i0, dut_out, tbl[k].exp);
            check(tbl[k].name, dut_out, tbl[k].exp);
        end

        // Async reset mid-attempt clears the digit count
        step(1, 0, "mid_d0");
        step(0, 1, "mid_d1");
        step(0, 1, "mid_d1b");
        #2 reset = 1'b0;
        #1 check("rst_mid_out", dut_out, 1'b0);
        model_reset();
        #1 reset = 1'b1;
        step(1, 0, "rem_0");
        step(1, 0, "rem_0b");
        step(0, 1, "rem_1");
        check("rst_mid_no_unlock", dut_out, 1'b0);
        step(1, 0, "fill_0");
        step(0, 1, "fill_1");
        step(0, 1, "fill_1b");
        check("rst_mid_mismatch", dut_out, 1'b0);
        enter_code("post_rst_code");
        check("post_rst_unlock", dut_out, 1'b1);
        step(0, 0, "unl_idle");
        // Async reset while unlocked drops out immediately
        #2 reset = 1'b0;
        #1 check("rst_unlocked_out", dut_out, 1'b0);
        model_reset();
        #1 reset = 1'b1;
        step(0, 0, "after_rst_idle");

`ifdef LOCK_LOCKOUT_EN
        // Three wrong attempts, then the correct code is ignored in lockout
        for (int k = 0; k < 3 * CODE_LEN; k++) step(1, 0, "wrong");
        enter_code("code_in_lockout");
        check("lockout_ignores_code", dut_out, 1'b0);
        for (int k = 0; k < LOCKOUT_CYCLES - CODE_LEN; k++) step(0, 0, "lockout_wait");
        enter_code("code_after_lockout");
        check("unlock_after_lockout", dut_out, 1'b1);
`endif

        // Randomized keys, sometimes salted with a correctly entered code
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(3) == 0) begin
                for (int k = CODE_LEN - 1; k >= 0; k--) begin
                    logic [5:0] c;
                    c = CODE;
                    if ($urandom_range(3) == 0) step(0, 0, "rnd_gap");
                    step(!c[k], c[k], "rnd_code");
                end
            end else begin
                case ($urandom_range(9))
                    0, 1, 2: begin r0 = 0; r1 = 0; end
                    3, 4, 5: begin r0 = 1; r1 = 0; end
                    6, 7, 8: begin r0 = 0; r1 = 1; end
                    default: begin r0 = 1; r1 = 1; end
                endcase
                step(r0, r1, "rnd_key");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lock_fsm.md
Name: lock_fsm

Overview:
- Sequential combination lock driven by two push-button inputs: inp0 enters digit 0, inp1 enters digit 1.
- One digit is sampled per clock edge and collected into a fixed-length attempt, which is compared against a parameterised code.
- A match asserts out (unlocked). It sits between debounced/synchronised button logic and the actuator driver.

Parameters:
- CODE_LEN, 6, number of digits per attempt (2..16).
- CODE, 6'b011001, unlock combination; MSB is the first digit entered (sequence 0,1,1,0,0,1).
- MAX_FAIL, 3, consecutive failed attempts before lockout (only with LOCK_LOCKOUT_EN).
- LOCKOUT_CYCLES, 16, lockout duration in clock cycles (only with LOCK_LOCKOUT_EN).

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- inp0  input  1  digit-0 key, synchronous, level sampled each edge.
- inp1  input  1  digit-1 key, synchronous, level sampled each edge.
- out  output  1  registered unlock indication; 1 = unlocked.

Behaviour:
- Reset (reset=0, async): state=LOCKED, digit count=0, shift register=0, fail count=0, out=0. Held while reset=0. Normal operation resumes on the first rising edge after deassertion.
- Input decode per edge:
  - inp0=1, inp1=0 → digit 0.
  - inp0=0, inp1=1 → digit 1.
  - 00 → idle: no entry, all state held; idle gaps inside an attempt are allowed.
  - 11 → abort: digit count=0, shift register cleared. Not counted as a failure. out unchanged unless UNLOCKED, in which case the lock relocks (out=0).
- States:
  - LOCKED: each digit shifts into the LSB of a CODE_LEN-bit register; count increments.
  - On the CODE_LEN-th digit, the complete value (register shifted with the new digit) is compared with CODE.
    - Match → UNLOCKED, count=0, fail count=0.
    - Mismatch → stay LOCKED, count=0, fail count +1 (saturating).
  - UNLOCKED: out=1. Held through idle cycles. Any digit relocks (out=0) and that digit is the first digit of a new attempt (count=1). Abort relocks with count=0.
- Latency: out rises on the same rising edge that samples the final correct digit (registered; visible from that edge to the next).
- No overlapping/sliding detection: attempts are framed strictly by the digit count. Extra digits start a new attempt.
- Both state and out change only on clock edges or on async reset; no combinational path from inputs to out.

Optional Feature:
- Macro LOCK_LOCKOUT_EN.
- Defined:
  - When fail count reaches MAX_FAIL, enter LOCKOUT and load a down-counter with LOCKOUT_CYCLES.
  - In LOCKOUT, all inputs are ignored and out=0.
  - When the counter reaches 0, return to LOCKED with fail count=0 and digit count=0.
- Undefined: fail counter and LOCKOUT state absent; unlimited attempts; MAX_FAIL/LOCKOUT_CYCLES unused.

Decomposition:
- Package lock_pkg: state enum (LOCKED, UNLOCKED, LOCKOUT), key-decode enum (KEY_IDLE, KEY_D0, KEY_D1, KEY_ABORT), default CODE/CODE_LEN constants.
- One sub-module: lock_key_decode (combinational inp0/inp1 → key enum). Shift/compare/FSM stay in top.

Test Plan:
- Reset: reset=0 for 5 cycles with random inputs → out=0 throughout; after release, the first correct sequence unlocks normally.
- Correct code with gaps: digits 0,1,1,0,0,1 with idle cycles interleaved → out=1 from the edge sampling the 6th digit; stays 1 through following idle cycles.
- Relock: from UNLOCKED, enter digits 0,0,1,1,0 then idle → out drops to 0 on the first digit; 5 digits entered, no compare, out=0. Completing with 1 gives 0,0,1,1,0,1 (mismatch) → out=0.
- Abort: 0,1,1, press both, then 0,1,1,0,0,1 → out=1 only after the full second sequence; fail count unchanged by abort.
- Async reset mid-attempt and while unlocked: assert reset between edges → out=0 immediately; count cleared (verify via 3 remaining digits not unlocking).
- Lockout (with LOCK_LOCKOUT_EN): 3 wrong 6-digit attempts, then correct code → out stays 0; correct code after 16 cycles of LOCKOUT → out=1.
